// File: rtl/mem_req_pkg.sv
// -----------------------------------------------------------------------------
// mem_req_pkg
// Shared types and helpers for the memory request front end (mem_request_unit).
//   state_e         : request FSM states
//   kind_e          : kind of the access in flight (instruction fetch, load, store)
//   RAM_LAT_DEFAULT : default ram read latency in cycles
//   addr_legal()    : word-aligned and inside the ram's word-address window
// -----------------------------------------------------------------------------
package mem_req_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } kind_e;

  localparam int RAM_LAT_DEFAULT = 1;

  // A byte address is usable only when it is word aligned and every bit above
  // the ram's word-address field is zero.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 32'd2);
    return (addr[1:0] == 2'b00) && (hi == 32'd0);
  endfunction

endpackage

// File: rtl/mem_request_unit.sv
// -----------------------------------------------------------------------------
// mem_request_unit
// Initiator-side front end for the shared instruction/data ram. It arbitrates
// one instruction-fetch and one load/store request (data first), drives the ram
// pins, waits out the ram read latency and returns the result with a one-cycle
// done pulse. The core is stalled while its request is outstanding.
//
// Parameters
//   ADDR_W  : ram word-address width
//   RAM_LAT : cycles from strobe to valid ram read data (1..7)
// Ports
//   clk, nRst                      : clock, synchronous active-high reset
//   fetch_req, pc                  : instruction fetch request and byte address
//   d_read_req, d_write_req        : load / store request
//   d_addr, d_wdata                : load/store byte address and store data
//   instr, instr_valid, instr_err  : fetch result, done pulse, error flag
//   d_rdata, d_done, d_err         : load result, done pulse, error flag
//   stall                          : freeze core while a request is pending
//   address_IM, address_DM         : ram instruction / data word address
//   read_enable, write_enable      : ram strobes
//   data_in                        : ram write data
//   data_out, instr_out            : ram data / instruction read ports
//   pc_enable                      : ram ready, strobes are held while low
// -----------------------------------------------------------------------------
module mem_request_unit
  import mem_req_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int RAM_LAT = RAM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              fetch_req,
  input  logic [31:0]       pc,
  input  logic              d_read_req,
  input  logic              d_write_req,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              instr_err,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              stall,
  output logic [ADDR_W-1:0] address_IM,
  output logic [ADDR_W-1:0] address_DM,
  output logic              read_enable,
  output logic              write_enable,
  output logic [31:0]       data_in,
  input  logic [31:0]       data_out,
  input  logic [31:0]       instr_out,
  input  logic              pc_enable
);

  state_e              state_q, state_d;
  kind_e               kind_q, kind_d;
  logic                err_q, err_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_im_q, addr_im_d;
  logic [ADDR_W-1:0]   addr_dm_q, addr_dm_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                any_req;
  logic                data_req;
  kind_e               req_kind;
  logic [31:0]         req_addr;
  logic                req_legal;
  logic [ADDR_W-1:0]   req_word;

  // Arbitration: store beats load, any data access beats a fetch.
  always_comb begin
    any_req   = fetch_req | d_read_req | d_write_req;
    data_req  = d_read_req | d_write_req;
    req_kind  = FETCH;
    if (d_write_req) begin
      req_kind = STORE;
    end else if (d_read_req) begin
      req_kind = LOAD;
    end
    req_addr  = data_req ? d_addr : pc;
    req_legal = addr_legal(req_addr, ADDR_W);
    req_word  = req_addr[ADDR_W+1:2];
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    rdata_d   = rdata_q;
    addr_im_d = addr_im_q;
    addr_dm_d = addr_dm_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          kind_d  = req_kind;
          wdata_d = d_wdata;
          err_d   = !req_legal;
          if (req_legal) begin
            state_d = ACCESS;
            if (req_kind == FETCH) begin
              addr_im_d = req_word;
            end else begin
              addr_dm_d = req_word;
            end
          end else begin
            // Illegal address: never touch the ram, answer with zero data.
            state_d = RESP;
            if (req_kind == FETCH) begin
              instr_d = '0;
            end else begin
              rdata_d = '0;
            end
          end
        end
      end
      ACCESS: begin
        if (pc_enable) begin
          state_d = WAIT;
          cnt_d   = 3'(RAM_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
          case (kind_q)
            FETCH:   instr_d = instr_out;
            LOAD:    rdata_d = data_out;
            default: rdata_d = '0;
          endcase
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        // Requests are not sampled here so the core can retire/replace them.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      state_q   <= IDLE;
      kind_q    <= FETCH;
      err_q     <= 1'b0;
      cnt_q     <= 3'd0;
      instr_q   <= '0;
      rdata_q   <= '0;
      addr_im_q <= '0;
      addr_dm_q <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      rdata_q   <= rdata_d;
      addr_im_q <= addr_im_d;
      addr_dm_q <= addr_dm_d;
    end
  end

  // Store data only reaches the pins through the ACCESS-gated data_in mux.
  always_ff @(posedge clk) begin
    wdata_q <= wdata_d;
  end

  always_comb begin
    read_enable  = (state_q == ACCESS) && (kind_q != STORE);
    write_enable = (state_q == ACCESS) && (kind_q == STORE);
    data_in      = write_enable ? wdata_q : '0;
    address_IM   = addr_im_q;
    address_DM   = addr_dm_q;
    instr        = instr_q;
    d_rdata      = rdata_q;
    instr_valid  = (state_q == RESP) && (kind_q == FETCH);
    instr_err    = instr_valid && err_q;
    d_done       = (state_q == RESP) && (kind_q != FETCH);
    d_err        = d_done && err_q;
    // Reset keeps stall low even if the core is already requesting.
    stall        = any_req && (state_q != RESP) && !nRst;
  end

endmodule

// File: tb/tb_mem_request_unit.sv
module tb_mem_request_unit;

  localparam int AW = 5;
  localparam int K_F = 0;
  localparam int K_L = 1;
  localparam int K_S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nRst [2];
  logic        fetch_req [2];
  logic        d_read_req [2];
  logic        d_write_req [2];
  logic        pc_enable [2];
  logic [31:0] pc [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic [31:0] instr [2];
  logic [31:0] d_rdata [2];
  logic [31:0] data_in [2];
  logic [31:0] data_out [2];
  logic [31:0] instr_out [2];
  logic        instr_valid [2];
  logic        instr_err [2];
  logic        d_done [2];
  logic        d_err [2];
  logic        stall [2];
  logic        read_enable [2];
  logic        write_enable [2];
  logic [AW-1:0] address_IM [2];
  logic [AW-1:0] address_DM [2];

  logic [31:0] ref_mem [2][32];
  logic [31:0] last_instr [2];
  logic [31:0] last_rdata [2];

  int n_tests = 0;
  int n_fail  = 0;

  mem_request_unit #(.ADDR_W(AW), .RAM_LAT(1)) u_dut_lat1 (
    .clk(clk), .nRst(nRst[0]), .fetch_req(fetch_req[0]), .pc(pc[0]),
    .d_read_req(d_read_req[0]), .d_write_req(d_write_req[0]),
    .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .instr(instr[0]), .instr_valid(instr_valid[0]), .instr_err(instr_err[0]),
    .d_rdata(d_rdata[0]), .d_done(d_done[0]), .d_err(d_err[0]), .stall(stall[0]),
    .address_IM(address_IM[0]), .address_DM(address_DM[0]),
    .read_enable(read_enable[0]), .write_enable(write_enable[0]),
    .data_in(data_in[0]), .data_out(data_out[0]), .instr_out(instr_out[0]),
    .pc_enable(pc_enable[0])
  );

  mem_request_unit #(.ADDR_W(AW), .RAM_LAT(3)) u_dut_lat3 (
    .clk(clk), .nRst(nRst[1]), .fetch_req(fetch_req[1]), .pc(pc[1]),
    .d_read_req(d_read_req[1]), .d_write_req(d_write_req[1]),
    .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .instr(instr[1]), .instr_valid(instr_valid[1]), .instr_err(instr_err[1]),
    .d_rdata(d_rdata[1]), .d_done(d_done[1]), .d_err(d_err[1]), .stall(stall[1]),
    .address_IM(address_IM[1]), .address_DM(address_DM[1]),
    .read_enable(read_enable[1]), .write_enable(write_enable[1]),
    .data_in(data_in[1]), .data_out(data_out[1]), .instr_out(instr_out[1]),
    .pc_enable(pc_enable[1])
  );

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  // Power-up content of the ram words; word 2 holds a known instruction.
  function automatic logic [31:0] seed(input int g, input int a);
    if (a == 2) return 32'hDEADBEEF;
    return 32'h5A00_0000 ^ (32'(a) * 32'h01F3_0A11) ^ (32'(g) << 8);
  endfunction

  function automatic logic legal_ref(input logic [31:0] a);
    return (a % 4 == 0) && (a < (32'd1 << (AW + 2)));
  endfunction

  function automatic logic [31:0] rand_addr();
    int m;
    m = int'($urandom_range(0, 7));
    if (m == 0) return {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
    if (m == 1) return 32'($urandom_range(32, 4000)) << 2;
    return {25'd0, 5'($urandom_range(0, 31)), 2'b00};
  endfunction

  // Ram model: reads registered on a strobe edge while ready, data shows up
  // RAM_LAT cycles after that edge for exactly one cycle, garbage otherwise.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] mem [32];
    logic [31:0] wv = '0;
    logic [32:0] pi [8];
    logic [32:0] pd [8];
    always @(posedge clk) begin
      if (write_enable[g] && pc_enable[g]) begin
        mem[address_DM[g]] <= data_in[g];
        wv[address_DM[g]]  <= 1'b1;
      end
      pi[0] <= (read_enable[g] && pc_enable[g]) ?
               {1'b1, (wv[address_IM[g]] ? mem[address_IM[g]] : seed(g, int'(address_IM[g])))} : 33'd0;
      pd[0] <= (read_enable[g] && pc_enable[g]) ?
               {1'b1, (wv[address_DM[g]] ? mem[address_DM[g]] : seed(g, int'(address_DM[g])))} : 33'd0;
      for (int i = 1; i < 8; i++) begin
        pi[i] <= pi[i-1];
        pd[i] <= pd[i-1];
      end
    end
    assign instr_out[g] = pi[L-1][32] ? pi[L-1][31:0] : 32'hBAD0_BAD0;
    assign data_out[g]  = pd[L-1][32] ? pd[L-1][31:0] : 32'hBAD0_BAD0;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input int u);
    string p;
    p = $sformatf("u%0d reset", u);
    chk({p, " instr"},        instr[u], 32'd0);
    chk({p, " d_rdata"},      d_rdata[u], 32'd0);
    chk({p, " data_in"},      data_in[u], 32'd0);
    chk({p, " address_IM"},   32'(address_IM[u]), 32'd0);
    chk({p, " address_DM"},   32'(address_DM[u]), 32'd0);
    chk({p, " read_enable"},  32'(read_enable[u]), 32'd0);
    chk({p, " write_enable"}, 32'(write_enable[u]), 32'd0);
    chk({p, " instr_valid"},  32'(instr_valid[u]), 32'd0);
    chk({p, " instr_err"},    32'(instr_err[u]), 32'd0);
    chk({p, " d_done"},       32'(d_done[u]), 32'd0);
    chk({p, " d_err"},        32'(d_err[u]), 32'd0);
    chk({p, " stall"},        32'(stall[u]), 32'd0);
  endtask

  // Drive one set of requests held like a core would, then follow every cycle
  // until each expected completion (data first, then fetch) has been seen.
  task automatic run_txn(input int u, input logic f, input logic rd, input logic wr,
                         input logic [31:0] pcv, input logic [31:0] da,
                         input logic [31:0] wd, input int st);
    int n, idx, start, done_k;
    int ek [2];
    int es [2];
    logic [31:0] ea [2];
    logic el [2];
    logic rs, ws, req_any;
    logic [4:0] w;
    logic [31:0] exp_d;
    string p;
    n = 0;
    if (rd || wr) begin
      ek[n] = wr ? K_S : K_L; ea[n] = da; es[n] = st; n++;
    end
    if (f) begin
      ek[n] = K_F; ea[n] = pcv; es[n] = (n == 0) ? st : 0; n++;
    end
    for (int i = 0; i < n; i++) el[i] = legal_ref(ea[i]);
    fetch_req[u] = f; d_read_req[u] = rd; d_write_req[u] = wr;
    pc[u] = pcv; d_addr[u] = da; d_wdata[u] = wd; pc_enable[u] = 1'b1;
    idx = 0; start = 0;
    done_k = el[0] ? 1 + es[0] + lat_of(u) : 0;
    for (int k = 0; k < 60 && idx < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      p = $sformatf("u%0d k%0d", u, k);
      rs = el[idx] && (k >= start) && (k <= start + es[idx]) && (ek[idx] != K_S);
      ws = el[idx] && (k >= start) && (k <= start + es[idx]) && (ek[idx] == K_S);
      req_any = fetch_req[u] | d_read_req[u] | d_write_req[u];
      chk({p, " stall"}, 32'(stall[u]), 32'(req_any && (k != done_k)));
      chk({p, " read_enable"}, 32'(read_enable[u]), 32'(rs));
      chk({p, " write_enable"}, 32'(write_enable[u]), 32'(ws));
      chk({p, " instr_valid"}, 32'(instr_valid[u]), 32'((k == done_k) && (ek[idx] == K_F)));
      chk({p, " d_done"}, 32'(d_done[u]), 32'((k == done_k) && (ek[idx] != K_F)));
      if (rs && ek[idx] == K_F) chk({p, " address_IM"}, 32'(address_IM[u]), 32'(ea[idx][AW+1:2]));
      if (rs && ek[idx] == K_L) chk({p, " address_DM"}, 32'(address_DM[u]), 32'(ea[idx][AW+1:2]));
      if (ws) begin
        chk({p, " address_DM"}, 32'(address_DM[u]), 32'(ea[idx][AW+1:2]));
        chk({p, " data_in"}, data_in[u], wd);
      end
      if (k == done_k) begin
        w = ea[idx][AW+1:2];
        if (ek[idx] == K_F) begin
          exp_d = el[idx] ? ref_mem[u][w] : 32'd0;
          chk({p, " instr"}, instr[u], exp_d);
          chk({p, " instr_err"}, 32'(instr_err[u]), 32'(!el[idx]));
          chk({p, " d_rdata held"}, d_rdata[u], last_rdata[u]);
          last_instr[u] = exp_d;
          fetch_req[u] = 1'b0;
        end else begin
          if (ek[idx] == K_L) begin
            exp_d = el[idx] ? ref_mem[u][w] : 32'd0;
          end else begin
            exp_d = 32'd0;
            if (el[idx]) ref_mem[u][w] = wd;
          end
          chk({p, " d_rdata"}, d_rdata[u], exp_d);
          chk({p, " d_err"}, 32'(d_err[u]), 32'(!el[idx]));
          chk({p, " instr held"}, instr[u], last_instr[u]);
          last_rdata[u] = exp_d;
          d_read_req[u] = 1'b0;
          d_write_req[u] = 1'b0;
        end
        idx++;
        if (idx < n) begin
          start = k + 2;
          done_k = el[idx] ? start + 1 + es[idx] + lat_of(u) : start;
        end
      end
      if (idx < n) pc_enable[u] = (k - start >= es[idx]);
    end
    if (idx < n) chk($sformatf("u%0d timeout", u), 32'(idx), 32'(n));
    fetch_req[u] = 1'b0; d_read_req[u] = 1'b0; d_write_req[u] = 1'b0;
    pc_enable[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, st;
    logic f, rd, wr;
    for (int u = 0; u < 2; u++) begin
      for (int a = 0; a < 32; a++) ref_mem[u][a] = seed(u, a);
      last_instr[u] = '0; last_rdata[u] = '0;
      nRst[u] = 1'b1; fetch_req[u] = 1'b1; pc[u] = 32'h8;
      d_read_req[u] = 1'b0; d_write_req[u] = 1'b0;
      d_addr[u] = '0; d_wdata[u] = '0; pc_enable[u] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outs(0);
    chk_reset_outs(1);

    for (int u = 0; u < 2; u++) begin
      nRst[u] = 1'b0;
      run_txn(u, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 0);
      run_txn(u, 1'b0, 1'b0, 1'b1, 32'h0, 32'hC, 32'h1234_5678, 0);
      run_txn(u, 1'b0, 1'b1, 1'b0, 32'h0, 32'hC, 32'h0, 0);
      run_txn(u, 1'b1, 1'b1, 1'b0, 32'h4, 32'h10, 32'h0, 0);
      run_txn(u, 1'b0, 1'b1, 1'b0, 32'h0, 32'h6, 32'h0, 0);
      run_txn(u, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 0);
      run_txn(u, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 3);
      for (int t = 0; t < 40; t++) begin
        sel = int'($urandom_range(0, 5));
        f  = (sel == 0) || (sel == 1) || (sel == 4) || (sel == 5);
        wr = (sel == 3) || (sel == 5);
        rd = (sel == 2) || (sel == 4) || (wr && ($urandom_range(0, 3) == 0));
        st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        run_txn(u, f, rd, wr, rand_addr(), rand_addr(), $urandom(), st);
      end
    end

    // Abort a fetch in the middle of the latency wait.
    pc[1] = 32'h14; fetch_req[1] = 1'b1; pc_enable[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nRst[1] = 1'b1; fetch_req[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outs(1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("u1 abort c%0d instr_valid", c), 32'(instr_valid[1]), 32'd0);
      chk($sformatf("u1 abort c%0d instr", c), instr[1], 32'd0);
    end
    nRst[1] = 1'b0;
    last_instr[1] = '0; last_rdata[1] = '0;
    run_txn(1, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 32'h0, 0);
    run_txn(1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hC, 32'h0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
